// File: rtl/axi4lite_regfile_slave.sv
// axi4lite_regfile_slave
//   AXI4-Lite slave register file of NUM_REGS words, each DATA_WIDTH bits wide.
//   The AW and W beats are accepted independently, in either order, and each
//   is latched into its own holding buffer. The edge after both buffers are
//   full commits the write, applying only the byte lanes whose strobe is set.
//   Registers flagged in RO_MASK are read-only: a read returns the matching
//   hw_status slice, and a write returns SLVERR. Any access outside
//   NUM_REGS also returns SLVERR; an out-of-range read returns zero data.
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   s_aw*, s_w*, s_b*          AXI4-Lite write address, write data and write response channels
//   s_ar*, s_r*                AXI4-Lite read address and read data channels
//   hw_status                  status words for read-only slots, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_q                      writable register contents, flat; read-only slots drive 0
module axi4lite_regfile_slave #(
  parameter int unsigned         ADDR_WIDTH = 6,
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [1:0]                     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFFS       = $clog2(STRB_WIDTH);
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Write holding buffers
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] aw_idx;
  logic [ADDR_WIDTH-1:0] ar_idx;
  logic                  wr_err;
  logic                  rd_err;
  logic [DATA_WIDTH-1:0] rd_val;

  assign s_awready = !aw_held && !s_bvalid;
  assign s_wready  = !w_held && !s_bvalid;
  assign s_arready = !s_rvalid;

  assign aw_hs  = s_awvalid && s_awready;
  assign w_hs   = s_wvalid && s_wready;
  assign commit = aw_held && w_held;

  // Shifting the whole address, rather than slicing it, keeps DATA_WIDTH=8
  // (no byte-offset bits) legal.
  assign aw_idx = aw_addr_q >> OFFS;
  assign ar_idx = s_araddr >> OFFS;

  // Indices that match no slot stay flagged as errors.
  always_comb begin
    wr_err = 1'b1;
    rd_err = 1'b1;
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (aw_idx == ADDR_WIDTH'(i)) begin
        wr_err = RO_MASK[i];
      end
      if (ar_idx == ADDR_WIDTH'(i)) begin
        rd_err = 1'b0;
        rd_val = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
      end
    end
  end

  // Write address/data acceptance, commit and response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
    end else begin
      if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        s_bvalid <= 1'b1;
        s_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= s_awaddr;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s_wdata;
          w_strb_q <= s_wstrb;
        end
      end
    end
  end

  // Register storage: only writable, in-range slots take the strobed byte lanes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (aw_idx == ADDR_WIDTH'(i) && !RO_MASK[i]) begin
          for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
            if (w_strb_q[b]) begin
              regs[i][b*8 +: 8] <= w_data_q[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Read channel: capture on AR handshake, hold until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
    end else if (s_arvalid && s_arready) begin
      s_rvalid <= 1'b1;
      s_rdata  <= rd_val;
      s_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (s_rvalid && s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
    end
  end

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// tb_axi4lite_regfile_slave
//   Directed bench for axi4lite_regfile_slave with ADDR_WIDTH=6, DATA_WIDTH=32,
//   NUM_REGS=8 and register 7 read-only. Expected values are hand-computed constants.
module tb_axi4lite_regfile_slave;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [5:0]   s_awaddr;
  logic         s_awvalid;
  logic         s_awready;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic         s_wvalid;
  logic         s_wready;
  logic [1:0]   s_bresp;
  logic         s_bvalid;
  logic         s_bready;
  logic [5:0]   s_araddr;
  logic         s_arvalid;
  logic         s_arready;
  logic [31:0]  s_rdata;
  logic [1:0]   s_rresp;
  logic         s_rvalid;
  logic         s_rready;
  logic [255:0] hw_status;
  logic [255:0] reg_q;

  axi4lite_regfile_slave #(
    .ADDR_WIDTH(6),
    .DATA_WIDTH(32),
    .NUM_REGS  (8),
    .RO_MASK   (8'h80)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_awaddr (s_awaddr),
    .s_awvalid(s_awvalid),
    .s_awready(s_awready),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_wvalid (s_wvalid),
    .s_wready (s_wready),
    .s_bresp  (s_bresp),
    .s_bvalid (s_bvalid),
    .s_bready (s_bready),
    .s_araddr (s_araddr),
    .s_arvalid(s_arvalid),
    .s_arready(s_arready),
    .s_rdata  (s_rdata),
    .s_rresp  (s_rresp),
    .s_rvalid (s_rvalid),
    .s_rready (s_rready),
    .hw_status(hw_status),
    .reg_q    (reg_q)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int unsigned n = 0;
    logic aw_go, w_go;
    @(negedge clk);
    s_awaddr = a; s_awvalid = 1'b1;
    s_wdata  = d; s_wstrb   = s; s_wvalid = 1'b1;
    s_bready = 1'b1;
    while ((s_awvalid || s_wvalid) && n < 20) begin
      aw_go = s_awvalid && s_awready;
      w_go  = s_wvalid && s_wready;
      @(negedge clk);
      if (aw_go) s_awvalid = 1'b0;
      if (w_go)  s_wvalid  = 1'b0;
      n++;
    end
    while (!s_bvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("wr_timeout", 0, 1);
    resp = s_bresp;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    @(negedge clk);
    s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    int unsigned n = 0;
    @(negedge clk);
    s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
    while (!s_arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    s_arvalid = 1'b0;
    while (!s_rvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("rd_timeout", 0, 1);
    d    = s_rdata;
    resp = s_rresp;
    @(negedge clk);
    s_rready = 1'b0;
  endtask

  logic [1:0]   resp, rresp;
  logic [31:0]  rdata;
  logic [255:0] exp_q;

  initial begin
    rst_n = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    hw_status = {8{32'hFFFF_FFFF}};
    hw_status[7*32 +: 32] = 32'hCAFE_0007;
    exp_q = '0;

    repeat (3) @(negedge clk);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_rdata", s_rdata, 0);
    check("rst_reg_q", reg_q, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_awready", s_awready, 1);
    check("idle_arready", s_arready, 1);

    // Full-word write and readback
    axi_write(6'h08, 32'hDEAD_BEEF, 4'hF, resp);
    check("t1_bresp", resp, 2'b00);
    exp_q[2*32 +: 32] = 32'hDEAD_BEEF;
    axi_read(6'h08, rdata, rresp);
    check("t1_rdata", rdata, 32'hDEAD_BEEF);
    check("t1_rresp", rresp, 2'b00);

    // Single byte lane
    axi_write(6'h0C, 32'h1122_3344, 4'hF, resp);
    axi_write(6'h0C, 32'h0000_00AA, 4'h1, resp);
    check("t2_bresp", resp, 2'b00);
    exp_q[3*32 +: 32] = 32'h1122_33AA;
    axi_read(6'h0C, rdata, rresp);
    check("t2_rdata", rdata, 32'h1122_33AA);
    axi_read(6'h0E, rdata, rresp);
    check("t2_offset_ignored", rdata, 32'h1122_33AA);

    // wstrb = 0 is OKAY and changes nothing
    axi_write(6'h08, 32'hFFFF_FFFF, 4'h0, resp);
    check("strb0_bresp", resp, 2'b00);
    axi_read(6'h08, rdata, rresp);
    check("strb0_rdata", rdata, 32'hDEAD_BEEF);

    // W ahead of AW, then a stalled response
    @(negedge clk);
    s_wdata = 32'h0000_A5A5; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b0;
    check("t3_wready", s_wready, 1);
    @(negedge clk);
    s_wvalid = 1'b0;
    check("t3_wready_held", s_wready, 0);
    check("t3_bvalid_w_only", s_bvalid, 0);
    repeat (2) @(negedge clk);
    s_awaddr = 6'h04; s_awvalid = 1'b1;
    check("t3_awready", s_awready, 1);
    @(negedge clk);
    s_awvalid = 1'b0;
    check("t3_bvalid_early", s_bvalid, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("t3_bvalid_stall", s_bvalid, 1);
      check("t3_bresp_stall", s_bresp, 2'b00);
      check("t3_awready_stall", s_awready, 0);
      check("t3_wready_stall", s_wready, 0);
      @(negedge clk);
    end
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
    check("t3_bvalid_done", s_bvalid, 0);
    exp_q[1*32 +: 32] = 32'h0000_A5A5;
    check("t3_reg_q", reg_q, exp_q);

    // Out-of-range access
    axi_write(6'h20, 32'h0000_0055, 4'hF, resp);
    check("t4_bresp", resp, 2'b10);
    check("t4_reg_q", reg_q, exp_q);
    axi_read(6'h20, rdata, rresp);
    check("t4_rdata", rdata, 32'h0);
    check("t4_rresp", rresp, 2'b10);

    // Read-only slot 7
    axi_read(6'h1C, rdata, rresp);
    check("t5_rdata", rdata, 32'hCAFE_0007);
    check("t5_rresp", rresp, 2'b00);
    axi_write(6'h1C, 32'h1234_5678, 4'hF, resp);
    check("t5_bresp", resp, 2'b10);
    axi_read(6'h1C, rdata, rresp);
    check("t5_rdata_after", rdata, 32'hCAFE_0007);
    check("t5_reg_q", reg_q, exp_q);

    // Reset with both responses pending
    @(negedge clk);
    s_awaddr = 6'h10; s_awvalid = 1'b1; s_wdata = 32'h7777_7777; s_wstrb = 4'hF; s_wvalid = 1'b1;
    s_araddr = 6'h08; s_arvalid = 1'b1; s_bready = 1'b0; s_rready = 1'b0;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    @(negedge clk);
    check("t6_bvalid_pre", s_bvalid, 1);
    check("t6_rvalid_pre", s_rvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_bvalid_rst", s_bvalid, 0);
    check("t6_rvalid_rst", s_rvalid, 0);
    check("t6_rdata_rst", s_rdata, 0);
    check("t6_reg_q_rst", reg_q, 0);
    @(negedge clk);
    rst_n = 1'b1;
    axi_write(6'h00, 32'h600D_F00D, 4'hF, resp);
    check("t6_bresp_after", resp, 2'b00);
    axi_read(6'h00, rdata, rresp);
    check("t6_rdata_after", rdata, 32'h600D_F00D);
    axi_read(6'h08, rdata, rresp);
    check("t6_reg2_cleared", rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
